spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-requester arbiter and sequencer for the team's single-port RAM (8-bit × 32-word, registered read address, combinational `q`). It accepts independent read/write requests from ports A and B, grants one at a time in round-robin order, and drives the RAM's `data`/`address`/`en`/`write_enable` pins. Read data comes back on the winning port with a registered valid pulse. It is the only block permitted to drive the RAM.

## Interface
- `DATA_W`, 8, data width; must match the RAM word.
- `ADDR_W`, 6, address width; only addresses 0..31 are legal.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_req` / `b_req`  in  1  request; held with its fields until the matching `gnt`.
- `a_we` / `b_we`  in  1  1 = write, 0 = read.
- `a_addr` / `b_addr`  in  ADDR_W  word address.
- `a_wdata` / `b_wdata`  in  DATA_W  write data.
- `a_gnt` / `b_gnt`  out  1  one-cycle pulse: request accepted; requester may change its fields next cycle.
- `a_rvalid` / `b_rvalid`  out  1  one-cycle pulse: `*_rdata` holds read result.
- `a_rdata` / `b_rdata`  out  DATA_W  registered read data; holds its value until the next read for that port.
- `ram_en`, `ram_we`  out  1  to RAM `en`, `write_enable`.
- `ram_addr`  out  ADDR_W  to RAM `address`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_q`  in  DATA_W  from RAM `q`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any `*_req`, pick winner, latch its `we`/`addr`/`wdata` and go to ACCESS; else stay.
  - ACCESS: `ram_we` = latched `we`, `ram_addr`/`ram_data` = latched values, winner's `gnt` = 1. Next state is IDLE for a write, RESP for a read.
  - RESP: `ram_addr` stays at latched address. Capture `ram_q` into winner's `rdata`; winner's `rvalid` = 1 on the following cycle. Next state is IDLE.
- The RAM overwrites `ram[address]` whenever `en` is low. `ram_en` is therefore 1 in every cycle after reset release.
  - Outside a write ACCESS, `ram_we` = 0, so the RAM only performs address-register reads.
  - Outside ACCESS/RESP, `ram_addr` holds the last latched address.
- Round-robin:
  - A 1-bit `last` pointer records the last winner.
  - On simultaneous requests, the port that is not `last` wins.
  - A single requester always wins.
  - `last` updates on entry to ACCESS.
- Requesters must drop or replace `req` in the cycle after `gnt`. A `req` still high in that cycle is a new request.
- An address of 32 or more is passed through unchecked; the resulting behaviour is undefined and treated as a requester bug.

## Timing
- Reset values:
  - state = IDLE, `last` = B (so A wins the first tie).
  - All `gnt`, `rvalid`, `ram_we`, `ram_en` = 0.
  - `ram_addr`, `ram_data`, `*_rdata` = 0.
- `ram_en` rises on the first edge after `rst` deasserts.
- Known effect of reset: RAM word 0 may be corrupted during reset.
- Request sampled at edge T0 (IDLE) gives:
  - ACCESS and `gnt` in cycle T0–T1; the RAM write or address capture happens at edge T1.
  - Reads: RESP in T1–T2; `rvalid`/`rdata` in T2–T3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `rvalid` of one transaction overlaps IDLE/ACCESS of the next. Back-to-back ops are legal.
- `rst` asserted mid-operation:
  - Immediate return to IDLE with outputs at reset values.
  - A write whose ACCESS edge has not occurred is not committed.
  - A pending read produces no `rvalid`.

## Configuration
- `SPRAM_ARB_FIXED_PRIO_EN` defined: round-robin is removed and `last` is not implemented; port A always wins simultaneous requests, so B can starve.
- `SPRAM_ARB_FIXED_PRIO_EN` undefined (default): round-robin as above.

## Test plan
- Reset, then A writes 0xA5 to address 3, then A reads address 3 -> `a_gnt` pulses once per op; `a_rvalid` 2 cycles after the read `gnt` with `a_rdata` = 0xA5.
- A and B both read, same cycle, addresses 5 (value 0x11) and 6 (value 0x22):
  - Default build: A granted first, then B; `a_rdata` = 0x11, `b_rdata` = 0x22.
  - Second tie: B wins.
- Both hold `req` continuously:
  - Default build: grants alternate A, B, A, B.
  - With `SPRAM_ARB_FIXED_PRIO_EN`: only A is granted.
- B writes 0x7E to address 31 while A writes 0x01 to address 31 in the same cycle -> A commits then B commits; a subsequent read of address 31 returns 0x7E.
- `rst` pulsed during ACCESS of a write of 0x55 to address 10, which previously held 0x33 -> the write is not committed and no `gnt` follows; a read of address 10 returns 0x33.
- Idle 20 cycles after writing 0x99 to address 8 -> `ram_en` stays 1 and `ram_we` stays 0 throughout; a read of address 8 returns 0x99.

Source files
------------

// File: rtl/spram_arbiter.sv
// -----------------------------------------------------------------------------
// spram_arbiter
//
// Two-requester arbiter and sequencer for the 8-bit x 32-word single-port RAM
// (registered read address, combinational q). Ports A and B each present one
// read or write request; requests are granted one at a time and the winner's
// fields are sequenced onto the RAM pins. Read data returns on the winning
// port with a registered one-cycle valid pulse. This block is the only driver
// of the RAM.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata and holds all of
// them until *_gnt is seen high. *_gnt is a one-cycle pulse during ACCESS; in
// the cycle after it the requester must drop *_req or replace the fields with
// a new request (a *_req still high then is a new request). Reads complete
// with *_rvalid pulsing for one cycle while *_rdata holds the read word;
// *_rdata keeps that value until the port's next read completes.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   a_req/b_req              request
//   a_we/b_we                1 = write, 0 = read
//   a_addr/b_addr            word address (0..31 legal; others pass unchecked)
//   a_wdata/b_wdata          write data
//   a_gnt/b_gnt              request accepted (one-cycle pulse)
//   a_rvalid/b_rvalid        read data valid (one-cycle pulse)
//   a_rdata/b_rdata          registered read data
//   ram_en, ram_we           RAM en / write_enable
//   ram_addr, ram_data       RAM address / data
//   ram_q                    RAM q
//
// Configuration macro: SPRAM_ARB_FIXED_PRIO_EN
//   undefined (default): round-robin on simultaneous requests.
//   defined: port A always wins simultaneous requests (B can starve).
// -----------------------------------------------------------------------------
module spram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              load;
  logic              pick_b;
  logic              win_b;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              en_q;

  // Winner selection, only meaningful while IDLE with at least one request.
`ifdef SPRAM_ARB_FIXED_PRIO_EN
  assign pick_b = b_req & ~a_req;
`else
  // last_b = 1 means B won most recently, so A takes the next tie.
  logic last_b;

  assign pick_b = b_req & (~a_req | ~last_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (load) begin
      last_b <= pick_b;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          state_next = ACCESS;
          load       = 1'b1;
        end
      end
      ACCESS:  state_next = lat_we ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      win_b    <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      // The RAM rewrites the addressed word whenever en is low, so en stays
      // high from the first edge after reset onwards.
      en_q     <= 1'b1;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (load) begin
        win_b    <= pick_b;
        lat_we   <= pick_b ? b_we    : a_we;
        lat_addr <= pick_b ? b_addr  : a_addr;
        lat_data <= pick_b ? b_wdata : a_wdata;
      end
      // In RESP the RAM's address register already holds lat_addr, so q is
      // the read word; capture it for the winner.
      if (state == RESP) begin
        if (win_b) begin
          b_rdata  <= ram_q;
          b_rvalid <= 1'b1;
        end else begin
          a_rdata  <= ram_q;
          a_rvalid <= 1'b1;
        end
      end
    end
  end

  assign a_gnt    = (state == ACCESS) & ~win_b;
  assign b_gnt    = (state == ACCESS) &  win_b;
  assign ram_we   = (state == ACCESS) &  lat_we;
  assign ram_en   = en_q;
  // Address/data hold the last latched values outside ACCESS/RESP.
  assign ram_addr = lat_addr;
  assign ram_data = lat_data;

endmodule

// File: tb/tb_spram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spram_arbiter
//
// Bench for spram_arbiter with a behavioural model of the RAM attached to the
// RAM pins. A reference model (memory array, round-robin pointer) updates at
// every observed grant and pushes expected read results into per-port queues;
// a monitor compares them when *_rvalid pulses. Directed scenarios are
// followed by concurrent randomized traffic on both ports.
// -----------------------------------------------------------------------------
module tb_spram_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;

  spram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [0:31];
  logic [AW-1:0] ram_areg;
  always @(posedge clk) begin
    if (!ram_en || ram_we) ram[ram_addr[4:0]] <= ram_data;
    ram_areg <= ram_addr;
  end
  assign ram_q = ram[ram_areg[4:0]];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q_a[$], exp_q_b[$];
  int            exp_c_a[$], exp_c_b[$];
  logic [DW-1:0] mem_model [0:31];
  bit            written [0:31];
  bit            last_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request fields as sampled by the DUT at the last rising edge.
  logic          pa_req = 0, pb_req = 0, pa_we = 0, pb_we = 0;
  logic [AW-1:0] pa_addr = '0, pb_addr = '0;
  logic [DW-1:0] pa_wdata = '0, pb_wdata = '0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pa_req   <= a_req;   pb_req   <= b_req;
    pa_we    <= a_we;    pb_we    <= b_we;
    pa_addr  <= a_addr;  pb_addr  <= b_addr;
    pa_wdata <= a_wdata; pb_wdata <= b_wdata;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit            exp_b, g_b, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    if (rst) begin
      last_b = 1'b1;
    end else begin
      if (a_gnt && b_gnt) begin
        check("gnt_both", {a_gnt, b_gnt}, 2'b00);
      end else if (a_gnt || b_gnt) begin
        check("gnt_had_req", {31'd0, pa_req | pb_req}, 1);
`ifdef SPRAM_ARB_FIXED_PRIO_EN
        exp_b = pb_req && !pa_req;
`else
        exp_b = pb_req && (!pa_req || !last_b);
`endif
        g_b = b_gnt;
        check("gnt_winner_b", {31'd0, g_b}, {31'd0, exp_b});
        g_we   = g_b ? pb_we    : pa_we;
        g_addr = g_b ? pb_addr  : pa_addr;
        g_data = g_b ? pb_wdata : pa_wdata;
        check("access_ram_we", {31'd0, ram_we}, {31'd0, g_we});
        check("access_ram_addr", {26'd0, ram_addr}, {26'd0, g_addr});
        check("access_ram_en", {31'd0, ram_en}, 1);
        if (g_we) begin
          check("access_ram_data", {24'd0, ram_data}, {24'd0, g_data});
          mem_model[g_addr[4:0]] = g_data;
        end else if (g_b) begin
          exp_q_b.push_back(mem_model[g_addr[4:0]]);
          exp_c_b.push_back(cyc + 2);
        end else begin
          exp_q_a.push_back(mem_model[g_addr[4:0]]);
          exp_c_a.push_back(cyc + 2);
        end
        last_b = g_b;
      end
      if (a_rvalid) begin
        if (exp_q_a.size() == 0) check("a_rvalid_unexpected", 1, 0);
        else begin
          check("a_rdata", {24'd0, a_rdata}, {24'd0, exp_q_a.pop_front()});
          check("a_rvalid_cycle", cyc, exp_c_a.pop_front());
        end
      end
      if (b_rvalid) begin
        if (exp_q_b.size() == 0) check("b_rvalid_unexpected", 1, 0);
        else begin
          check("b_rdata", {24'd0, b_rdata}, {24'd0, exp_q_b.pop_front()});
          check("b_rvalid_cycle", cyc, exp_c_b.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request and returns at the falling edge where gnt is seen,
  // with req still high; the caller replaces or releases it next cycle.
  task automatic do_op(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    bit got = 0;
    @(negedge clk);
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (port ? b_gnt : a_gnt) got = 1;
    end
    if (!got) begin
      check(port ? "b_gnt_timeout" : "a_gnt_timeout", 0, 1);
      if (port) b_req = 0; else a_req = 0;
    end
  endtask

  task automatic release_port(input bit port);
    @(negedge clk);
    if (port) b_req = 0; else a_req = 0;
  endtask

  task automatic read_check(input bit port, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp, input string name);
    bit seen = 0;
    do_op(port, 1'b0, addr, '0);
    release_port(port);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (port ? b_rvalid : a_rvalid) begin
        seen = 1;
        check(name, {24'd0, port ? b_rdata : a_rdata}, {24'd0, exp});
      end
    end
    if (!seen) check({name, "_rvalid_timeout"}, 0, 1);
  endtask

  task automatic write_op(input bit port, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    do_op(port, 1'b1, addr, data);
    release_port(port);
  endtask

  task automatic random_port(input bit port, input int n);
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            we;
      addr = AW'($urandom_range(1, 31));
      data = DW'($urandom);
      we   = $urandom_range(0, 1) == 1;
      if (!written[addr[4:0]]) we = 1;
      do_op(port, we, addr, data);
      if (we) written[addr[4:0]] = 1;
      release_port(port);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a_cnt, b_cnt;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_a_gnt", {31'd0, a_gnt}, 0);
    check("rst_b_gnt", {31'd0, b_gnt}, 0);
    check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    check("rst_ram_we", {31'd0, ram_we}, 0);
    check("rst_ram_en", {31'd0, ram_en}, 0);
    check("rst_ram_addr", {26'd0, ram_addr}, 0);
    check("rst_ram_data", {24'd0, ram_data}, 0);
    check("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
    rst = 0;
    #1 check("ram_en_before_edge", {31'd0, ram_en}, 0);
    @(negedge clk);
    check("ram_en_after_edge", {31'd0, ram_en}, 1);

    // A writes then reads back
    write_op(0, 6'd3, 8'hA5);
    read_check(0, 6'd3, 8'hA5, "a_read_addr3");

    // Simultaneous reads; last winner is B before the first tie
    write_op(0, 6'd5, 8'h11);
    write_op(1, 6'd6, 8'h22);
    repeat (2) @(negedge clk);
    fork
      read_check(0, 6'd5, 8'h11, "tie1_a_rdata");
      read_check(1, 6'd6, 8'h22, "tie1_b_rdata");
    join
    repeat (2) @(negedge clk);
    fork
      read_check(0, 6'd5, 8'h11, "tie2_a_rdata");
      read_check(1, 6'd6, 8'h22, "tie2_b_rdata");
    join

    // Both hold req continuously
    repeat (2) @(negedge clk);
    a_cnt = 0; b_cnt = 0;
    a_we = 0; a_addr = 6'd5; b_we = 0; b_addr = 6'd6;
    a_req = 1; b_req = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (a_gnt) a_cnt++;
      if (b_gnt) b_cnt++;
    end
    a_req = 0; b_req = 0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    check("hold_b_grants", b_cnt, 0);
    check("hold_a_grants_ge4", {31'd0, a_cnt >= 4}, 1);
`else
    check("hold_a_grants_ge2", {31'd0, a_cnt >= 2}, 1);
    check("hold_b_grants_ge2", {31'd0, b_cnt >= 2}, 1);
`endif
    repeat (6) @(negedge clk);

    // Same-address write collision; B goes last beforehand so A wins the tie
    read_check(1, 6'd6, 8'h22, "pre_collision_b");
    fork
      write_op(0, 6'd31, 8'h01);
      write_op(1, 6'd31, 8'h7E);
    join
    read_check(0, 6'd31, 8'h7E, "collision_addr31");

    // Reset during ACCESS of a write
    write_op(0, 6'd10, 8'h33);
    repeat (3) @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 6'd10; a_wdata = 8'h55;
    @(posedge clk);
    #1 check("rst_test_gnt_before", {31'd0, a_gnt}, 1);
    rst = 1; a_req = 0; a_we = 0;
    #1 check("rst_test_gnt_after", {31'd0, a_gnt}, 0);
    check("rst_test_ram_we", {31'd0, ram_we}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_test_ram_en", {31'd0, ram_en}, 1);
    read_check(0, 6'd10, 8'h33, "rst_test_addr10");

    // Long idle after a write
    write_op(1, 6'd8, 8'h99);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ram_en", {31'd0, ram_en}, 1);
      check("idle_ram_we", {31'd0, ram_we}, 0);
    end
    read_check(1, 6'd8, 8'h99, "idle_addr8");

    // Randomized concurrent traffic
    fork
      random_port(0, 30);
      random_port(1, 30);
    join
    repeat (10) @(negedge clk);
    check("a_queue_drained", exp_q_a.size(), 0);
    check("b_queue_drained", exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
